mult_control_fsm: RTL

Sequencing controller for the 8-bit signed add-shift multiplier. It sits directly upstream of the 17-bit X:A:B shift-register datapath and the 9-bit add/subtract unit. It converts the operator's Run and ClearA_LoadB switches into the per-cycle Load_B, ClearAX, Compute, Fn and Shift_En strobes. It runs exactly eight add/shift iterations per multiply and subtracts on the final iteration, which implements two's-complement multiplier correction.

---
 rtl/mult_control_fsm.sv | 114 +++++++++++
 1 files changed

// File: rtl/mult_control_fsm.sv
// Sequencer for the 8-bit signed add-shift multiplier (X:A:B datapath, 9-bit add/sub unit).
// Optional macro MULT_SKIP_ZERO_ADD_EN: an ADD with M=0 is folded into a shift cycle.
module mult_control_fsm (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Load_B,
    output logic ClearAX,
    output logic Compute,
    output logic Fn,
    output logic Shift_En,
    output logic Done
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StAdd,
        StShift,
        StHold
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       last_iter;
    logic       do_shift;

    assign last_iter = (cnt_q == 3'd7);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        Load_B   = 1'b0;
        ClearAX  = 1'b0;
        Compute  = 1'b0;
        Fn       = 1'b0;
        Shift_En = 1'b0;
        Done     = 1'b0;
        do_shift = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A load request takes priority over starting a multiply.
                if (ClearA_LoadB) begin
                    Load_B  = 1'b1;
                    ClearAX = 1'b1;
                end else if (Run) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                ClearAX = 1'b1;
                cnt_d   = 3'd0;
                state_d = StAdd;
            end
            StAdd: begin
`ifdef MULT_SKIP_ZERO_ADD_EN
                if (M) begin
                    Compute = 1'b1;
                    Fn      = last_iter;
                    state_d = StShift;
                end else begin
                    do_shift = 1'b1;
                end
`else
                Compute = M;
                Fn      = last_iter;
                state_d = StShift;
`endif
            end
            StShift: begin
                do_shift = 1'b1;
            end
            StHold: begin
                Done = 1'b1;
                if (!Run) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Shared shift step; cnt freezes at 7 so no wrap is visible in HOLD.
        if (do_shift) begin
            Shift_En = 1'b1;
            if (last_iter) begin
                state_d = StHold;
            end else begin
                cnt_d   = cnt_q + 3'd1;
                state_d = StAdd;
            end
        end
    end

    a_strobe_excl: assert property (@(posedge Clk) disable iff (Reset)
        $onehot0({Load_B, Compute, Shift_En}));
    a_clear_only_with_load: assert property (@(posedge Clk) disable iff (Reset)
        ClearAX |-> !(Compute || Shift_En || Done));

endmodule
